// File: rtl/hamming_uart_tx.sv
// hamming_uart_tx
//   Serialises 7-bit Hamming(7,4) code words onto a UART line: one start bit,
//   seven code bits LSB first, an optional even-parity bit, then STOP_BITS
//   stop bits. A shift register plus one holding register let consecutive
//   words go out back-to-back with no idle cycles.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per UART bit (>= 2)
//   STOP_BITS     number of stop bits (1 or 2)
//
// Optional feature
//   UART_PARITY_EN  when defined, a PARITY bit (XOR of the 7 code bits,
//                   captured at shifter load) is sent between DATA and STOP.
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   code_in     code word, bit 0 transmitted first
//   in_valid    code_in is valid
//   in_ready    a word can be accepted this cycle (= hold register empty)
//   tx          UART serial output, idles high
//   busy        a frame is in progress
//   frame_done  one-cycle pulse on the final cycle of the last stop bit

module hamming_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] code_in,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    DATA_LAST = 3'd6;
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [6:0]    shift;
    logic [6:0]    hold_word;
    logic          hold_full;
`ifdef UART_PARITY_EN
    logic          parity_bit;
`endif

    logic bit_end;
    logic accept;
    logic frame_end;
    logic load_new;
    logic load_hold;
    logic to_hold;

    // Next-state logic and load routing.
    always_comb begin
        state_next = state;
        frame_end  = 1'b0;
        load_new   = 1'b0;
        load_hold  = 1'b0;
        bit_end    = (baud_cnt == BAUD_LAST);
        accept     = in_valid && !hold_full;

        case (state)
            IDLE: begin
                if (accept) begin
                    load_new   = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (bit_end) state_next = DATA;
            end
            DATA: begin
                if (bit_end && bit_idx == DATA_LAST) begin
`ifdef UART_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                if (bit_end) state_next = STOP;
            end
`endif
            STOP: begin
                if (bit_end && bit_idx == STOP_LAST) begin
                    frame_end = 1'b1;
                    // in_ready is low whenever hold is full, so the hold
                    // transfer and a direct load can never coincide.
                    if (hold_full) begin
                        load_hold  = 1'b1;
                        state_next = START;
                    end else if (accept) begin
                        load_new   = 1'b1;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        to_hold = accept && !load_new;
    end

    // Output decode from registered state.
    always_comb begin
        tx = 1'b1;
        case (state)
            START:   tx = 1'b0;
            DATA:    tx = shift[0];
`ifdef UART_PARITY_EN
            PARITY:  tx = parity_bit;
`endif
            default: tx = 1'b1;
        endcase
    end

    assign in_ready   = !hold_full;
    assign busy       = (state != IDLE);
    assign frame_done = frame_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            hold_word  <= '0;
            hold_full  <= 1'b0;
`ifdef UART_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            state <= state_next;

            if (state == IDLE || bit_end) baud_cnt <= '0;
            else                          baud_cnt <= baud_cnt + CW'(1);

            // bit_idx counts data bits in DATA and stop bits in STOP.
            if (state_next != state)
                bit_idx <= '0;
            else if (bit_end && (state == DATA || state == STOP))
                bit_idx <= bit_idx + 3'd1;

            if (load_new) begin
                shift      <= code_in;
`ifdef UART_PARITY_EN
                parity_bit <= ^code_in;
`endif
            end else if (load_hold) begin
                shift      <= hold_word;
`ifdef UART_PARITY_EN
                parity_bit <= ^hold_word;
`endif
            end else if (state == DATA && bit_end) begin
                shift <= {1'b0, shift[6:1]};
            end

            if (to_hold) begin
                hold_word <= code_in;
                hold_full <= 1'b1;
            end else if (load_hold) begin
                hold_full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hamming_uart_tx.sv
// tb_hamming_uart_tx
//   Self-checking bench for hamming_uart_tx (CLKS_PER_BIT=4, STOP_BITS=1).
//   The reference is a queue of expected per-cycle line values: each accepted
//   word appends its whole frame, so back-to-back frames follow naturally and
//   the block is ready whenever at most one frame is outstanding.
//   Honors UART_PARITY_EN the same way as the design.

module tb_hamming_uart_tx;

    localparam int unsigned CPB = 4;
    localparam int unsigned SB  = 1;
`ifdef UART_PARITY_EN
    localparam int unsigned PB  = 1;
`else
    localparam int unsigned PB  = 0;
`endif
    localparam int unsigned NBITS = 8 + PB + SB;
    localparam int unsigned FL    = NBITS * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [6:0] code_in = '0;
    logic       in_ready;
    logic       tx;
    logic       busy;
    logic       frame_done;

    hamming_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .STOP_BITS   (SB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .code_in   (code_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .tx        (tx),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic tx;
        logic last;
    } slot_t;

    slot_t q[$];
    bit    m_ready = 1'b1;
    bit    m_acc   = 1'b0;
    bit    chk_en  = 1'b0;
    int    n_cmp   = 0;
    int    n_bad   = 0;

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [6:0] w);
        logic  bits[$];
        slot_t s;
        bits.push_back(1'b0);
        for (int i = 0; i < 7; i++) bits.push_back(w[i]);
`ifdef UART_PARITY_EN
        bits.push_back(^w);
`endif
        for (int i = 0; i < int'(SB); i++) bits.push_back(1'b1);
        for (int b = 0; b < bits.size(); b++) begin
            for (int c = 0; c < int'(CPB); c++) begin
                s.tx   = bits[b];
                s.last = (b == bits.size() - 1) && (c == int'(CPB) - 1);
                q.push_back(s);
            end
        end
    endtask

    // Reference model: front of q is the expected line value this cycle.
    always @(posedge clk) begin
        m_acc = 1'b0;
        if (rst) begin
            q.delete();
        end else begin
            if (q.size() > 0) void'(q.pop_front());
            if (in_valid && m_ready) begin
                m_acc = 1'b1;
                push_frame(code_in);
            end
        end
        m_ready = (q.size() <= FL);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("tx",         tx,         (q.size() != 0) ? q[0].tx   : 1'b1);
            check("frame_done", frame_done, (q.size() != 0) ? q[0].last : 1'b0);
            check("busy",       busy,       q.size() != 0);
            check("in_ready",   in_ready,   m_ready);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [6:0] w);
        int n = 0;
        code_in  = w;
        in_valid = 1'b1;
        do begin
            tick();
            n++;
        end while (!m_acc && n < 400);
        in_valid = 1'b0;
        check("accept_wait", m_acc, 1'b1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (q.size() != 0 && n < 1000) begin
            tick();
            n++;
        end
        check("idle_wait", q.size() == 0, 1'b1);
        repeat (2) tick();
    endtask

`ifdef UART_PARITY_EN
    logic exp1 [NBITS] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
    logic exp1 [NBITS] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
`endif

    initial begin
        // Reset with in_valid asserted: nothing may be accepted.
        rst      = 1'b1;
        in_valid = 1'b1;
        code_in  = 7'h55;
        tick();
        chk_en = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("rst_tx",       tx,         1'b1);
        check("rst_busy",     busy,       1'b0);
        check("rst_in_ready", in_ready,   1'b1);
        check("rst_fdone",    frame_done, 1'b0);
        repeat (4) tick();

        // Single frame, literal bit-period and end-of-frame checks.
        send(7'b1010101);
        for (int n = 1; n <= int'(FL) + 1; n++) begin
            @(negedge clk);
            if ((n - 1) % int'(CPB) == int'(CPB) / 2)
                check("single_bit", tx, exp1[(n - 1) / int'(CPB)]);
            if (n == int'(FL))     check("single_fdone", frame_done, 1'b1);
            if (n == int'(FL) + 1) check("single_busy_low", busy, 1'b0);
        end
        tick();
        wait_idle();

        // Back-to-back: second word goes to hold, follows with no gap.
        send(7'h0F);
        send(7'h70);
        @(negedge clk);
        check("b2b_ready_low", in_ready, 1'b0);
        repeat (FL - 2) @(negedge clk);
        check("b2b_fdone", frame_done, 1'b1);
        @(negedge clk);
        check("b2b_start2", tx, 1'b0);
        check("b2b_busy", busy, 1'b1);
        check("b2b_ready_back", in_ready, 1'b1);
        tick();
        wait_idle();

        // Backpressure: 7'h33 waits while hold is full.
        send(7'h0F);
        send(7'h70);
        code_in  = 7'h33;
        in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("bp_ready_low", in_ready, 1'b0);
        end
        send(7'h33);
        wait_idle();

        // Reset during DATA bit 3 with a word in hold.
        send(7'h5A);
        send(7'h2C);
        repeat (16) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_tx", tx, 1'b1);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_ready", in_ready, 1'b1);
        repeat (FL + 2) tick();
        send(7'h11);
        wait_idle();

        // Extreme patterns back-to-back.
        send(7'h00);
        send(7'h7F);
        wait_idle();

`ifdef UART_PARITY_EN
        send(7'b0000111);
        repeat (34) @(negedge clk);
        check("parity_one", tx, 1'b1);
        tick();
        wait_idle();
        send(7'b0000011);
        repeat (34) @(negedge clk);
        check("parity_zero", tx, 1'b0);
        tick();
        wait_idle();
`endif

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
